// File: rtl/rvcpu_pkg.sv
// rvcpu_pkg: shared register-index type and register count for the rvcpu core
package rvcpu;
  typedef logic [4:0] reg_t;
  localparam int NumRegs = 32;
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port with valid/x0 masking and write-through bypass
module regfile_rdport
  import rvcpu::*;
#(
  parameter int Width = 32
) (
  input  logic [NumRegs-1:1][Width-1:0] regs_i,
  input  reg_t                          rs_i,
  input  logic                          rs_valid_i,
  input  logic                          reset_i,
  input  logic                          we_i,
  input  reg_t                          rw_i,
  input  logic [Width-1:0]              wval_i,
  output logic [Width-1:0]              rd_o
);
  // rs_i != 0 already excludes rw_i == 0 from the bypass
  always_comb
    rd_o = (!rs_valid_i || rs_i == '0) ? '0 :
           (we_i && !reset_i && rw_i == rs_i) ? wval_i : regs_i[rs_i];
endmodule

// File: rtl/regfile.sv
// regfile: 32 x Width integer register file, x0 hardwired to zero,
// two combinational read ports and one synchronous write port
module regfile
  import rvcpu::*;
#(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  reg_t             rs1,
  input  logic             rs1_valid,
  input  reg_t             rs2,
  input  logic             rs2_valid,
  input  reg_t             rw,
  input  logic             we,
  input  logic [Width-1:0] wval,
  output logic [Width-1:0] rd1,
  output logic [Width-1:0] rd2
);
  logic [NumRegs-1:1][Width-1:0] regs_q, regs_d;
  always_comb begin
    regs_d = regs_q;
    if (we && rw != '0) regs_d[rw] = wval;
  end
  always_ff @(posedge clk)
    regs_q <= reset ? '0 : regs_d;
  regfile_rdport #(.Width(Width)) u_rd1 (
    .regs_i(regs_q), .rs_i(rs1), .rs_valid_i(rs1_valid), .reset_i(reset),
    .we_i(we), .rw_i(rw), .wval_i(wval), .rd_o(rd1)
  );
  regfile_rdport #(.Width(Width)) u_rd2 (
    .regs_i(regs_q), .rs_i(rs2), .rs_valid_i(rs2_valid), .reset_i(reset),
    .we_i(we), .rw_i(rw), .wval_i(wval), .rd_o(rd2)
  );
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: scoreboard bench for regfile against a reference register array
module tb_regfile;
  import rvcpu::*;
  localparam int W = 32;
  logic clk = 0, reset = 1;
  reg_t rs1 = '0, rs2 = '0, rw = '0;
  logic rs1_valid = 0, rs2_valid = 0, we = 0;
  logic [W-1:0] wval = '0, rd1, rd2;
  logic [W-1:0] mdl [NumRegs];
  logic [W-1:0] q1 [$], q2 [$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  regfile #(.Width(W)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs1_valid(rs1_valid), .rs2(rs2),
    .rs2_valid(rs2_valid), .rw(rw), .we(we), .wval(wval), .rd1(rd1), .rd2(rd2)
  );
  task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] model_rd(reg_t a, logic v);
    if (!v || a == '0) return '0;
    if (we && !reset && rw == a) return wval;
    return mdl[a];
  endfunction
  task automatic rd(string tag, reg_t a, logic va, reg_t b, logic vb);
    rs1 = a; rs1_valid = va; rs2 = b; rs2_valid = vb;
    q1.push_back(model_rd(a, va));
    q2.push_back(model_rd(b, vb));
    #1;
    check({tag, "/rd1"}, rd1, q1.pop_front());
    check({tag, "/rd2"}, rd2, q2.pop_front());
  endtask
  task automatic step();
    @(posedge clk);
    if (reset) foreach (mdl[i]) mdl[i] = '0;
    else if (we && rw != '0) mdl[rw] = wval;
    @(negedge clk);
  endtask
  task automatic wr(reg_t r, logic [W-1:0] v);
    we = 1; rw = r; wval = v;
    step();
    we = 0;
  endtask
  initial begin
    foreach (mdl[i]) mdl[i] = '0;
    @(negedge clk);
    step();
    reset = 0;
    for (int i = 1; i < NumRegs; i++) rd("rst_clear", reg_t'(i), 1, reg_t'(i), 1);
    wr(1, 123);
    rd("wr_x1", 1, 1, 0, 0);
    rd("x0_read", 0, 1, 0, 1);
    wr(0, 'hDEAD);
    rd("x0_wr_ignored", 0, 1, 0, 1);
    wr(2, 456);
    rd("two_ports", 2, 1, 1, 1);
    rd("same_reg", 2, 1, 2, 1);
    rd("valid_mask", 1, 0, 1, 1);
    we = 1; rw = 5; wval = 77;
    rd("bypass", 1, 0, 5, 1);
    rd("bypass_both", 5, 1, 5, 1);
    step();
    we = 0;
    rd("x5_after", 5, 1, 5, 1);
    wr(3, 11);
    reset = 1; we = 1; rw = 3; wval = 9;
    rd("rst_no_bypass", 3, 1, 3, 1);
    step();
    reset = 0; we = 0;
    rd("rst_x3", 3, 1, 5, 1);
    rd("rst_x1x2", 1, 1, 2, 1);
    wr(4, 'h55AA);
    rd("post_rst_wr", 4, 1, 3, 1);
    for (int i = 0; i < 200; i++) begin
      reset = ($urandom_range(0, 24) == 0);
      we = 1'($urandom_range(0, 1));
      rw = reg_t'($urandom_range(0, 31));
      wval = $urandom;
      rd("rnd", reg_t'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
           reg_t'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0));
      step();
    end
    reset = 0; we = 0;
    for (int i = 1; i < NumRegs; i++) rd("final", reg_t'(i), 1, reg_t'(NumRegs - i), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
